// File: rtl/s_axi_stream_fifo_pkg.sv
// Shared types and defaults for the AXI4-Stream ingress FIFO.
// Holds the write-framing state encoding and the RAM entry width helper.
package s_axi_stream_fifo_pkg;

   localparam int DWIDTH_DEF  = 32;
   localparam int BUFSIZE_DEF = 4;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RECV = 1'b1
   } wr_state_e;

   // One RAM entry holds {tlast, tstrb, tdata}.
   function automatic int entry_width(input int dw);
      return dw + dw / 8 + 1;
   endfunction

endpackage

// File: rtl/s_axi_stream_fifo_ram.sv
// Simple dual-port storage for the stream FIFO: synchronous write, asynchronous read.
// The asynchronous read is what gives the pop port its zero-latency show-ahead.
module s_axi_stream_fifo_ram #(
   parameter int AW = 4,
   parameter int W  = 37
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [W-1:0]  wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [W-1:0]  rdata_o
);

   logic [W-1:0] mem_q [2**AW];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/s_axi_stream_fifo.sv
// AXI4-Stream slave feeding a show-ahead FIFO with packet tracking.
// PKT_MODE=1 holds packets until their tlast beat lands, falling back to cut-through on oversize.
module s_axi_stream_fifo
   import s_axi_stream_fifo_pkg::*;
#(
   parameter int DWIDTH   = DWIDTH_DEF,
   parameter int BUFSIZE  = BUFSIZE_DEF,
   parameter int PKT_MODE = 0
) (
   input  logic                clk,
   input  logic                xrst,
   input  logic                tvalid,
   output logic                tready,
   input  logic [DWIDTH-1:0]   tdata,
   input  logic [DWIDTH/8-1:0] tstrb,
   input  logic                tlast,
   input  logic                rd_en,
   output logic                rd_valid,
   output logic [DWIDTH-1:0]   rd_data,
   output logic [DWIDTH/8-1:0] rd_strb,
   output logic                rd_last,
   output logic [BUFSIZE:0]    count,
   output logic [BUFSIZE:0]    pkt_count,
   output logic                oversize
);

   localparam int SW = DWIDTH / 8;
   localparam int EW = entry_width(DWIDTH);
   localparam logic [BUFSIZE:0] FULL_CNT = {1'b1, {BUFSIZE{1'b0}}};
   localparam logic [BUFSIZE:0] ONE_CNT  = {{BUFSIZE{1'b0}}, 1'b1};

   logic [BUFSIZE-1:0] wptr_q, wptr_d;
   logic [BUFSIZE-1:0] rptr_q, rptr_d;
   logic [BUFSIZE:0]   count_q, count_d;
   logic [BUFSIZE:0]   pkt_q, pkt_d;
   logic               tready_q, tready_d;
   logic               cut_q, cut_d;
   logic               over_q, over_d;
   wr_state_e          state_q, state_d;

   logic               full, empty, accept, store, pop;
   logic [EW-1:0]      ram_rdata;

   s_axi_stream_fifo_ram #(
      .AW (BUFSIZE),
      .W  (EW)
   ) u_ram (
      .clk     (clk),
      .we_i    (store),
      .waddr_i (wptr_q),
      .wdata_i ({tlast, tstrb, tdata}),
      .raddr_i (rptr_q),
      .rdata_o (ram_rdata)
   );

   assign rd_data   = ram_rdata[DWIDTH-1:0];
   assign rd_strb   = ram_rdata[DWIDTH +: SW];
   assign rd_last   = ram_rdata[EW-1];
   assign tready    = tready_q;
   assign count     = count_q;
   assign pkt_count = pkt_q;
   assign oversize  = (PKT_MODE != 0) ? over_q : 1'b0;

   // Null beats (no strobes, not last) complete the handshake but never reach the RAM.
   always_comb begin
      full   = (count_q == FULL_CNT);
      empty  = (count_q == '0);
      accept = tvalid & tready_q;
      store  = accept & ((|tstrb) | tlast);
      if (PKT_MODE != 0) rd_valid = ~empty & ((pkt_q != '0) | cut_q);
      else               rd_valid = ~empty;
      pop      = rd_en & rd_valid;
      wptr_d   = wptr_q + BUFSIZE'(store);
      rptr_d   = rptr_q + BUFSIZE'(pop);
      count_d  = count_q + (BUFSIZE+1)'(store) - (BUFSIZE+1)'(pop);
      pkt_d    = pkt_q + (BUFSIZE+1)'(store & tlast) - (BUFSIZE+1)'(pop & rd_last);
      tready_d = (count_d != FULL_CNT);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept && !tlast) state_d = S_RECV;
         S_RECV:  if (accept && tlast)  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // A full FIFO holding only part of one packet can never complete it, so release it as cut-through.
   always_comb begin
      cut_d  = cut_q;
      over_d = over_q;
      if (PKT_MODE != 0) begin
         if (full && (state_q == S_RECV) && (pkt_q == '0)) begin
            cut_d  = 1'b1;
            over_d = 1'b1;
         end else if (pop && rd_last && (pkt_q == ONE_CNT) && !(store && tlast)) begin
            cut_d  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         count_q  <= '0;
         pkt_q    <= '0;
         tready_q <= 1'b0;
         cut_q    <= 1'b0;
         over_q   <= 1'b0;
         state_q  <= S_IDLE;
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         count_q  <= count_d;
         pkt_q    <= pkt_d;
         tready_q <= tready_d;
         cut_q    <= cut_d;
         over_q   <= over_d;
         state_q  <= state_d;
      end
   end

endmodule
